// File: rtl/fpu_addsub_issue_pkg.sv
// Shared FPU definitions: condition-code bit positions, canonical quiet NaN and FIFO entry layout.
package fpu_addsub_issue_pkg;

  localparam int unsigned FpuBitWidth = 16;
  localparam int unsigned FpuExpWidth = 5;
  localparam int unsigned FpuSigWidth = 10;

  // Bit positions within a {Z,C,N,V} condition-code nibble.
  localparam int unsigned CcZ = 3;
  localparam int unsigned CcC = 2;
  localparam int unsigned CcN = 1;
  localparam int unsigned CcV = 0;

  typedef struct packed {
    logic                   sub;
    logic [FpuBitWidth-1:0] op1;
    logic [FpuBitWidth-1:0] op2;
  } fifoEntry_t;

  // {0, all-ones exponent, fraction MSB set, rest zero}; callers truncate to their width.
  function automatic logic [63:0] canonicalQnan(input int unsigned expWidth,
                                                input int unsigned sigWidth);
    logic [63:0] nan;
    nan = ((64'd1 << expWidth) - 64'd1) << sigWidth;
    nan = nan | (64'd1 << (sigWidth - 1));
    return nan;
  endfunction

endpackage

// File: rtl/fpu_op_fifo.sv
// Parameterised synchronous FIFO with asynchronous active-high reset and occupancy count.
module fpu_op_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           popData,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int unsigned PtrWidth   = $clog2(DEPTH);
  localparam int unsigned CountWidth = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PtrWidth-1:0] wrPtr, rdPtr;
  logic                doPush, doPop;

  assign empty   = (count == '0);
  assign doPush  = push && (count < CountWidth'(DEPTH));
  assign doPop   = pop && !empty;
  assign popData = mem[rdPtr];

  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PtrWidth'(1);
      if (doPop)  rdPtr <= rdPtr + PtrWidth'(1);
      unique case ({doPush, doPop})
        2'b10:   count <= count + CountWidth'(1);
        2'b01:   count <= count - CountWidth'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_addsub_issue.sv
// Issue/retire stage around the combinational FPU add/sub unit.
// Define FPU_SPECIAL_CASE_EN to resolve NaN/Inf operands locally instead of using the unit's result.
module fpu_addsub_issue
  import fpu_addsub_issue_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = FpuBitWidth,
  parameter int unsigned EXP_WIDTH  = FpuExpWidth,
  parameter int unsigned SIG_WIDTH  = FpuSigWidth,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic                 inSub,
  input  logic [BIT_WIDTH-1:0] inOp1,
  input  logic [BIT_WIDTH-1:0] inOp2,
  output logic                 sub,
  output logic [BIT_WIDTH-1:0] fpuAddSubIn1,
  output logic [BIT_WIDTH-1:0] fpuAddSubIn2,
  output logic                 fpuAddSubS1,
  output logic                 fpuAddSubS2,
  output logic [EXP_WIDTH-1:0] fpuAddSubE1,
  output logic [EXP_WIDTH-1:0] fpuAddSubE2,
  output logic [SIG_WIDTH-1:0] fpuAddSubSig1,
  output logic [SIG_WIDTH-1:0] fpuAddSubSig2,
  input  logic [BIT_WIDTH-1:0] fpuAddSubOut,
  input  logic [3:0]           condCodes,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [BIT_WIDTH-1:0] outResult,
  output logic [3:0]           outCondCodes,
  output logic                 outSpecial,
  output logic [15:0]          opCount
);
  localparam int unsigned CountWidth = $clog2(FIFO_DEPTH + 1);

  fifoEntry_t            pushEntry, headEntry;
  logic [CountWidth-1:0] fifoCount;
  logic                  fifoEmpty;
  logic                  issueValid, issueLoad, retireAdvance;
  logic                  isSpecial;
  logic [BIT_WIDTH-1:0]  specialResult;
  logic [3:0]            specialCond;

  assign pushEntry     = '{sub: inSub, op1: inOp1, op2: inOp2};
  assign inReady       = (fifoCount < CountWidth'(FIFO_DEPTH));
  assign retireAdvance = issueValid && (!outValid || outReady);
  assign issueLoad     = !fifoEmpty && (!issueValid || retireAdvance);

  fpu_op_fifo #(
    .WIDTH($bits(fifoEntry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (inValid && inReady),
    .pushData(pushEntry),
    .pop     (issueLoad),
    .popData (headEntry),
    .count   (fifoCount),
    .empty   (fifoEmpty)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issueValid    <= 1'b0;
      sub           <= 1'b0;
      fpuAddSubIn1  <= '0;
      fpuAddSubIn2  <= '0;
      fpuAddSubS1   <= 1'b0;
      fpuAddSubS2   <= 1'b0;
      fpuAddSubE1   <= '0;
      fpuAddSubE2   <= '0;
      fpuAddSubSig1 <= '0;
      fpuAddSubSig2 <= '0;
    end else if (issueLoad) begin
      issueValid    <= 1'b1;
      sub           <= headEntry.sub;
      fpuAddSubIn1  <= headEntry.op1;
      fpuAddSubIn2  <= headEntry.op2;
      fpuAddSubS1   <= headEntry.op1[BIT_WIDTH-1];
      fpuAddSubS2   <= headEntry.op2[BIT_WIDTH-1];
      fpuAddSubE1   <= headEntry.op1[BIT_WIDTH-2 -: EXP_WIDTH];
      fpuAddSubE2   <= headEntry.op2[BIT_WIDTH-2 -: EXP_WIDTH];
      fpuAddSubSig1 <= headEntry.op1[SIG_WIDTH-1:0];
      fpuAddSubSig2 <= headEntry.op2[SIG_WIDTH-1:0];
    end else if (retireAdvance) begin
      issueValid <= 1'b0;
    end
  end

`ifdef FPU_SPECIAL_CASE_EN
  logic nan1, nan2, inf1, inf2, effS2, infSign;

  always_comb begin
    nan1          = (&fpuAddSubE1) && (|fpuAddSubSig1);
    nan2          = (&fpuAddSubE2) && (|fpuAddSubSig2);
    inf1          = (&fpuAddSubE1) && !(|fpuAddSubSig1);
    inf2          = (&fpuAddSubE2) && !(|fpuAddSubSig2);
    effS2         = fpuAddSubS2 ^ sub;
    infSign       = inf1 ? fpuAddSubS1 : effS2;
    isSpecial     = nan1 || nan2 || inf1 || inf2;
    specialCond   = 4'b0000;
    specialResult = '0;
    // Opposite-signed infinities cancel to NaN just like a NaN operand does.
    if (nan1 || nan2 || (inf1 && inf2 && (fpuAddSubS1 != effS2))) begin
      specialResult    = BIT_WIDTH'(canonicalQnan(EXP_WIDTH, SIG_WIDTH));
      specialCond[CcV] = 1'b1;
    end else begin
      specialResult    = {infSign, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
      specialCond[CcN] = infSign;
    end
  end
`else
  assign isSpecial     = 1'b0;
  assign specialResult = '0;
  assign specialCond   = 4'b0000;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      outValid     <= 1'b0;
      outResult    <= '0;
      outCondCodes <= 4'b0000;
      outSpecial   <= 1'b0;
      opCount      <= 16'd0;
    end else begin
      if (retireAdvance) begin
        outValid     <= 1'b1;
        outResult    <= isSpecial ? specialResult : fpuAddSubOut;
        outCondCodes <= isSpecial ? specialCond : condCodes;
        outSpecial   <= isSpecial;
      end else if (outReady) begin
        outValid <= 1'b0;
      end
      if (outValid && outReady) opCount <= opCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_issue.sv
// Directed self-checking bench for fpu_addsub_issue with a stubbed add/sub unit.
module tb_fpu_addsub_issue;

  logic        clock, reset;
  logic        inValid, inReady, inSub;
  logic [15:0] inOp1, inOp2;
  logic        sub;
  logic [15:0] fpuAddSubIn1, fpuAddSubIn2;
  logic        fpuAddSubS1, fpuAddSubS2;
  logic [4:0]  fpuAddSubE1, fpuAddSubE2;
  logic [9:0]  fpuAddSubSig1, fpuAddSubSig2;
  logic [15:0] fpuAddSubOut;
  logic [3:0]  condCodes;
  logic        outValid, outReady;
  logic [15:0] outResult;
  logic [3:0]  outCondCodes;
  logic        outSpecial;
  logic [15:0] opCount;

  int checks = 0;
  int errors = 0;

  // Stub unit: plain integer sum plus sub, cond = {sub, sign1, sign2, 1}.
  function automatic logic [15:0] stubOut(input logic [15:0] a, input logic [15:0] b,
                                          input logic s);
    return a + b + {15'd0, s};
  endfunction

  function automatic logic [3:0] stubCc(input logic [15:0] a, input logic [15:0] b,
                                        input logic s);
    return {s, a[15], b[15], 1'b1};
  endfunction

  assign fpuAddSubOut = stubOut(fpuAddSubIn1, fpuAddSubIn2, sub);
  assign condCodes    = stubCc(fpuAddSubIn1, fpuAddSubIn2, sub);

  fpu_addsub_issue dut (
    .clock        (clock),
    .reset        (reset),
    .inValid      (inValid),
    .inReady      (inReady),
    .inSub        (inSub),
    .inOp1        (inOp1),
    .inOp2        (inOp2),
    .sub          (sub),
    .fpuAddSubIn1 (fpuAddSubIn1),
    .fpuAddSubIn2 (fpuAddSubIn2),
    .fpuAddSubS1  (fpuAddSubS1),
    .fpuAddSubS2  (fpuAddSubS2),
    .fpuAddSubE1  (fpuAddSubE1),
    .fpuAddSubE2  (fpuAddSubE2),
    .fpuAddSubSig1(fpuAddSubSig1),
    .fpuAddSubSig2(fpuAddSubSig2),
    .fpuAddSubOut (fpuAddSubOut),
    .condCodes    (condCodes),
    .outValid     (outValid),
    .outReady     (outReady),
    .outResult    (outResult),
    .outCondCodes (outCondCodes),
    .outSpecial   (outSpecial),
    .opCount      (opCount)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pushOp(input logic s, input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    inSub = s; inOp1 = a; inOp2 = b; inValid = 1'b1;
    while (!inReady && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("push_timeout", 32'd0, 32'd1);
    tick();
    inValid = 1'b0;
  endtask

  task automatic expectRetire(input string tag, input logic [15:0] res, input logic [3:0] cc,
                              input logic sp);
    int n;
    n = 0;
    outReady = 1'b1;
    while (!outValid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, outValid, 1);
    check({tag, "_result"}, outResult, res);
    check({tag, "_cond"}, outCondCodes, cc);
    check({tag, "_special"}, outSpecial, sp);
    tick();
  endtask

  int          accepted, pushed, retired, cycles;
  logic        acc, ret, sawValid;
  logic [15:0] countAtFfff;

  initial begin
    reset = 1'b1; inValid = 1'b0; inSub = 1'b0; inOp1 = '0; inOp2 = '0; outReady = 1'b0;
    #2;
    check("rst_inReady", inReady, 1);
    check("rst_outValid", outValid, 0);
    check("rst_outResult", outResult, 0);
    check("rst_opCount", opCount, 0);
    check("rst_in1", fpuAddSubIn1, 0);
    check("rst_special", outSpecial, 0);
    repeat (2) tick();
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Single add: latency and field unpacking.
    inValid = 1'b1; inSub = 1'b0; inOp1 = 16'h3C00; inOp2 = 16'h4000; outReady = 1'b1;
    tick();
    inValid = 1'b0;
    check("add_not_issued", fpuAddSubIn1, 16'h0000);
    tick();
    check("add_e1", fpuAddSubE1, 5'h0F);
    check("add_e2", fpuAddSubE2, 5'h10);
    check("add_sig1", fpuAddSubSig1, 0);
    check("add_sig2", fpuAddSubSig2, 0);
    check("add_sub", sub, 0);
    check("add_in1", fpuAddSubIn1, 16'h3C00);
    check("add_early_valid", outValid, 0);
    tick();
    check("add_valid", outValid, 1);
    check("add_result", outResult, 16'h7C00);
    check("add_cond", outCondCodes, 4'b0001);
    check("add_special", outSpecial, 0);
    tick();
    check("add_opCount", opCount, 1);
    check("add_valid_clear", outValid, 0);

    // Back-pressure: only FIFO_DEPTH + 2 ops fit.
    outReady = 1'b0;
    accepted = 0;
    for (int i = 0; i < 5; i++) begin
      inValid = 1'b1;
      inSub = i[0];
      inOp1 = 16'h1000 + 16'(i);
      inOp2 = 16'(i * 256);
      if (inReady) accepted++;
      tick();
    end
    inValid = 1'b0;
    check("bp_accepted", 32'(accepted), 4);
    check("bp_inReady_low", inReady, 0);
    check("bp_hold_result", outResult, stubOut(16'h1000, 16'h0000, 1'b0));
    outReady = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("bp_order_valid", outValid, 1);
      check("bp_order_result", outResult, stubOut(16'h1000 + 16'(k), 16'(k * 256), k[0]));
      tick();
    end
    check("bp_drained", outValid, 0);
    check("bp_opCount", opCount, 5);

    // Special values.
    pushOp(1'b0, 16'h7E00, 16'h3C00);
`ifdef FPU_SPECIAL_CASE_EN
    expectRetire("nan", 16'h7E00, 4'b0001, 1'b1);
`else
    expectRetire("nan", 16'hBA00, 4'b0001, 1'b0);
`endif
    pushOp(1'b1, 16'h7C00, 16'h7C00);
`ifdef FPU_SPECIAL_CASE_EN
    expectRetire("inf_cancel", 16'h7E00, 4'b0001, 1'b1);
`else
    expectRetire("inf_cancel", 16'hF801, 4'b1001, 1'b0);
`endif
    pushOp(1'b1, 16'h7C00, 16'hFC00);
`ifdef FPU_SPECIAL_CASE_EN
    expectRetire("inf_same", 16'h7C00, 4'b0000, 1'b1);
`else
    expectRetire("inf_same", 16'h7801, 4'b1011, 1'b0);
`endif

    // Asynchronous reset with three ops in flight.
    outReady = 1'b0;
    pushOp(1'b0, 16'h1111, 16'h2222);
    pushOp(1'b0, 16'h0101, 16'h0202);
    pushOp(1'b1, 16'h0303, 16'h0404);
    check("pre_rst_valid", outValid, 1);
    check("pre_rst_result", outResult, 16'h3333);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_valid", outValid, 0);
    check("mid_rst_inReady", inReady, 1);
    check("mid_rst_result", outResult, 0);
    check("mid_rst_cond", outCondCodes, 0);
    check("mid_rst_in1", fpuAddSubIn1, 0);
    check("mid_rst_sub", sub, 0);
    check("mid_rst_opCount", opCount, 0);
    @(negedge clock);
    reset = 1'b0;
    outReady = 1'b1;
    sawValid = 1'b0;
    repeat (6) begin
      tick();
      if (outValid) sawValid = 1'b1;
    end
    check("post_rst_no_retire", sawValid, 0);
    check("post_rst_inReady", inReady, 1);

    // Stream 65536 ops at full rate; the counter must wrap to zero.
    pushed = 0; retired = 0; cycles = 0; countAtFfff = '0;
    inSub = 1'b0; inOp1 = 16'h3C00; inOp2 = 16'h3C00; outReady = 1'b1;
    while (retired < 65536 && cycles < 66000) begin
      inValid = (pushed < 65536);
      acc = inValid && inReady;
      ret = outValid && outReady;
      tick();
      cycles++;
      if (acc) pushed++;
      if (ret) retired++;
      if (ret && retired == 65535) countAtFfff = opCount;
    end
    inValid = 1'b0;
    check("wrap_retired", 32'(retired), 65536);
    check("wrap_ffff", countAtFfff, 16'hFFFF);
    check("wrap_zero", opCount, 16'h0000);
    check("wrap_cycles", 32'(cycles), 65539);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
